// File: rtl/camera_dvp_source.sv
// camera_dvp_source: replays 32-bit FIFO words as DVP vsync/href/byte frames.
// Define CAM_TX_TEST_PATTERN_EN to replace FIFO data with an internal diagonal ramp.
module camera_dvp_source #(
  parameter int unsigned VSYNC_LEN  = 8,
  parameter int unsigned VBP_LEN    = 16,
  parameter int unsigned HBLANK_LEN = 32,
  parameter int unsigned VFP_LEN    = 16,
  parameter logic [7:0]  FILL_BYTE  = 8'h00
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        pic_format,
  input  logic [11:0] cfg_width,
  input  logic [11:0] cfg_height,
  input  logic [31:0] word_data,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data_out,
  output logic        frame_done,
  output logic        underflow,
  output logic        busy
);

  localparam int unsigned MAX_AB =
    (VSYNC_LEN > VBP_LEN) ? VSYNC_LEN : VBP_LEN;
  localparam int unsigned MAX_CD =
    (HBLANK_LEN > VFP_LEN) ? HBLANK_LEN : VFP_LEN;
  localparam int unsigned MAX_LEN =
    (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBP,
    S_ACTIVE,
    S_HBLANK,
    S_VFP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [12:0]   byte_q, byte_d;
  logic [11:0]   line_q, line_d;
  logic [11:0]   width_q, width_d;
  logic [11:0]   height_q, height_d;
  logic          fmt_q, fmt_d;
  logic          uf_q, uf_d;
  logic          fd_q, fd_d;
  logic          vsync_q, vsync_d;
  logic          href_q, href_d;
  logic [7:0]    data_q, data_d;
  logic          start;

  logic [CW-1:0] cnt_inc;
  logic [12:0]   line_bytes;
  logic [12:0]   byte_nx;
  logic          more;
  logic          last_line;
  logic          vs_end;
  logic          vbp_end;
  logic          hb_end;
  logic          vfp_end;

  assign cnt_inc    = cnt_q + CW'(1);
  assign line_bytes = fmt_q ? {width_q, 1'b0} : {1'b0, width_q};
  assign byte_nx    = byte_q + 13'd1;
  assign more       = byte_nx < line_bytes;
  assign last_line  = line_q == (height_q - 12'd1);
  assign vs_end     = cnt_q == CW'(VSYNC_LEN - 1);
  assign vbp_end    = cnt_q == CW'(VBP_LEN - 1);
  assign hb_end     = cnt_q == CW'(HBLANK_LEN - 1);
  assign vfp_end    = cnt_q == CW'(VFP_LEN - 1);

`ifndef CAM_TX_TEST_PATTERN_EN
  logic [31:0] sh_q, sh_d;
  logic [31:0] grp;
  logic        fetch;

  // a new 4-byte group is requested one cycle before its lane-0 byte
  assign fetch =
    (state_q == S_VBP    && vbp_end) ||
    (state_q == S_HBLANK && hb_end)  ||
    (state_q == S_ACTIVE && byte_q[1:0] == 2'd3 && more);

  assign grp        = word_valid ? word_data : {4{FILL_BYTE}};
  assign word_ready = fetch;
`else
  logic unused_fifo;

  assign unused_fifo = ^{word_data, word_valid};
  assign word_ready  = 1'b0;
`endif

  // frame sequencing, counters and per-frame config latch
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    line_d   = line_q;
    width_d  = width_q;
    height_d = height_q;
    fmt_d    = fmt_q;
    uf_d     = uf_q;
    fd_d     = 1'b0;
    start    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable) start = 1'b1;
      end
      S_VSYNC: begin
        if (vs_end) begin
          state_d = S_VBP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_VBP: begin
        if (vbp_end) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
          byte_d  = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_ACTIVE: begin
        if (more) begin
          byte_d = byte_nx;
        end else begin
          byte_d = '0;
          cnt_d  = '0;
          if (last_line) begin
            state_d = S_VFP;
          end else begin
            state_d = S_HBLANK;
            line_d  = line_q + 12'd1;
          end
        end
      end
      S_HBLANK: begin
        if (hb_end) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_VFP: begin
        if (vfp_end) begin
          fd_d  = 1'b1;
          cnt_d = '0;
          if (enable) start = 1'b1;
          else state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
`ifndef CAM_TX_TEST_PATTERN_EN
    if (fetch && !word_valid) uf_d = 1'b1;
`endif
    if (start) begin
      state_d  = S_VSYNC;
      cnt_d    = '0;
      byte_d   = '0;
      line_d   = '0;
      width_d  = cfg_width;
      height_d = cfg_height;
      fmt_d    = pic_format;
      uf_d     = 1'b0;
    end
  end

  // registered DVP outputs follow the next state
  always_comb begin
    vsync_d = state_d == S_VSYNC;
    href_d  = state_d == S_ACTIVE;
    data_d  = 8'h00;
`ifndef CAM_TX_TEST_PATTERN_EN
    sh_d = sh_q;
    if (href_d) begin
      if (fetch) begin
        data_d = grp[7:0];
        sh_d   = {8'h00, grp[31:8]};
      end else begin
        data_d = sh_q[7:0];
        sh_d   = {8'h00, sh_q[31:8]};
      end
    end
`else
    if (href_d) data_d = byte_d[7:0] + line_d[7:0];
`endif
  end

  // state and output registers
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      byte_q   <= '0;
      line_q   <= '0;
      width_q  <= '0;
      height_q <= '0;
      fmt_q    <= 1'b0;
      uf_q     <= 1'b0;
      fd_q     <= 1'b0;
      vsync_q  <= 1'b0;
      href_q   <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      line_q   <= line_d;
      width_q  <= width_d;
      height_q <= height_d;
      fmt_q    <= fmt_d;
      uf_q     <= uf_d;
      fd_q     <= fd_d;
      vsync_q  <= vsync_d;
      href_q   <= href_d;
      data_q   <= data_d;
    end
  end

`ifndef CAM_TX_TEST_PATTERN_EN
  // byte shift register for the current word
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) sh_q <= '0;
    else sh_q <= sh_d;
  end
`endif

  assign vsync      = vsync_q;
  assign href       = href_q;
  assign data_out   = data_q;
  assign frame_done = fd_q;
  assign underflow  = uf_q;
  assign busy       = state_q != S_IDLE;

endmodule
